// File: rtl/cs_stats_reader.sv
// Reads NUM_WORDS statistics counters from a peripheral responder by writing a word
// index and then reading back the selected counter; each word goes out through a
// valid/ready handshake.
module cs_stats_reader #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] STATS_ADDR = ADDR_W'(32'h0000_0100),
  parameter int                NUM_WORDS  = 6
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              req_cs_o,
  output logic              rw_cs_o,
  output logic [ADDR_W-1:0] add_cs_o,
  output logic [31:0]       data_cs_o,
  input  logic [31:0]       data_cs_i,
  output logic [31:0]       word_o,
  output logic [2:0]        word_idx_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  state_t            state_reg, state_next;
  logic [2:0]        idx_reg, idx_next;

  logic              req_next;
  logic              rw_next;
  logic [ADDR_W-1:0] add_next;
  logic [31:0]       data_next;
  logic              valid_next;
  logic              busy_next;
  logic              done_next;
  logic              capture;

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg <= S_IDLE;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic; abort drops straight to IDLE since SEL and RD are single-cycle
  // bus transfers that are already complete by the edge that sees the abort.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          idx_next   = 3'd0;
          state_next = S_SEL;
        end
      end
      S_SEL:  state_next = abort_i ? S_IDLE : S_RD;
      S_RD:   state_next = abort_i ? S_IDLE : S_CAP;
      S_CAP:  state_next = abort_i ? S_IDLE : S_OUT;
      S_OUT: begin
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (ready_i) begin
          if (idx_reg < LAST_IDX) begin
            idx_next   = idx_reg + 3'd1;
            state_next = S_SEL;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    req_next   = (state_next == S_SEL) || (state_next == S_RD);
    rw_next    = (state_next == S_SEL);
    add_next   = req_next ? STATS_ADDR : '0;
    data_next  = (state_next == S_SEL) ? {29'b0, idx_next} : 32'd0;
    valid_next = (state_next == S_OUT);
    busy_next  = (state_next != S_IDLE);
    done_next  = (state_next == S_DONE);
    capture    = (state_reg == S_CAP) && (state_next == S_OUT);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      req_cs_o   <= 1'b0;
      rw_cs_o    <= 1'b0;
      add_cs_o   <= '0;
      data_cs_o  <= 32'd0;
      word_o     <= 32'd0;
      word_idx_o <= 3'd0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      req_cs_o   <= req_next;
      rw_cs_o    <= rw_next;
      add_cs_o   <= add_next;
      data_cs_o  <= data_next;
      valid_o    <= valid_next;
      busy_o     <= busy_next;
      done_o     <= done_next;
      if (capture) begin
        word_o     <= data_cs_i;
        word_idx_o <= idx_reg;
      end
    end
  end

endmodule
